heap_level_insert: RTL and testbench

HEAP_LEVEL_INSERT -- requirements
Module: heap_level_insert

---
 rtl/heap_pkg.sv | 14 +
 rtl/heap_level_insert_if.sv | 33 +++
 rtl/heap_cmp_swap.sv | 42 ++++
 rtl/heap_level_insert.sv | 172 +++++++++++++++++
 tb/tb_heap_level_insert.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/heap_pkg.sv
// Shared types and default widths for the heap insert pipeline levels.
package heap_pkg;

  localparam int HEAP_CNT_SIZE    = 20;
  localparam int HEAP_ADDR_SIZE   = 28;
  localparam int HEAP_TOTAL_LEVEL = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_PUSH = 2'd2
  } heap_state_e;

endpackage

// File: rtl/heap_level_insert_if.sv
// Token handshakes of one heap level: insert from the level above, forward to the level below.
interface heap_level_insert_if
  import heap_pkg::*;
#(
  parameter int CNT_SIZE    = HEAP_CNT_SIZE,
  parameter int ADDR_SIZE   = HEAP_ADDR_SIZE,
  parameter int TOTAL_LEVEL = HEAP_TOTAL_LEVEL
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [TOTAL_LEVEL-1:0] in_index;
  logic [CNT_SIZE-1:0]    in_cnt;
  logic [ADDR_SIZE-1:0]   in_addr;

  logic                   out_valid;
  logic                   out_ready;
  logic [TOTAL_LEVEL-1:0] out_index;
  logic [CNT_SIZE-1:0]    out_cnt;
  logic [ADDR_SIZE-1:0]   out_addr;

  // master: the surrounding pipeline (upstream producer and downstream consumer)
  modport master (
    output in_valid, in_index, in_cnt, in_addr, out_ready,
    input  in_ready, out_valid, out_index, out_cnt, out_addr
  );

  modport slave (
    input  in_valid, in_index, in_cnt, in_addr, out_ready,
    output in_ready, out_valid, out_index, out_cnt, out_addr
  );

endinterface

// File: rtl/heap_cmp_swap.sv
// Compare a token against the stored node entry; decide what stays and what moves down.
module heap_cmp_swap
  import heap_pkg::*;
#(
  parameter int CNT_SIZE  = HEAP_CNT_SIZE,
  parameter int ADDR_SIZE = HEAP_ADDR_SIZE
) (
  input  logic [CNT_SIZE-1:0]  tok_cnt,
  input  logic [ADDR_SIZE-1:0] tok_addr,
  input  logic [CNT_SIZE-1:0]  st_cnt,
  input  logic [ADDR_SIZE-1:0] st_addr,
  output logic                 do_write,
  output logic                 do_fwd,
  output logic [CNT_SIZE-1:0]  keep_cnt,
  output logic [ADDR_SIZE-1:0] keep_addr,
  output logic [CNT_SIZE-1:0]  fwd_cnt,
  output logic [ADDR_SIZE-1:0] fwd_addr
);

  always_comb begin
    do_write  = 1'b0;
    do_fwd    = 1'b0;
    keep_cnt  = tok_cnt;
    keep_addr = tok_addr;
    fwd_cnt   = tok_cnt;
    fwd_addr  = tok_addr;
    // a zero count is a null token; a zero stored count marks an empty node
    if (tok_cnt != '0) begin
      if (st_cnt == '0) begin
        do_write = 1'b1;
      end else if (tok_cnt > st_cnt) begin
        do_write = 1'b1;
        do_fwd   = 1'b1;
        fwd_cnt  = st_cnt;
        fwd_addr = st_addr;
      end else begin
        do_fwd = 1'b1;
      end
    end
  end

endmodule

// File: rtl/heap_level_insert.sv
// One level of a pipelined max-heap insert: place the token in its node or push the loser
// to a child node on the next level, alternating children per node.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | in_ready high, waiting for an insert token
// CMP     | token vs stored node; write and/or offer forward this cycle
// PUSH    | forward entry held on out_* until the next level takes it
module heap_level_insert
  import heap_pkg::*;
#(
  parameter int CNT_SIZE      = HEAP_CNT_SIZE,
  parameter int ADDR_SIZE     = HEAP_ADDR_SIZE,
  parameter int TOTAL_LEVEL   = HEAP_TOTAL_LEVEL,
  parameter int CURRENT_LEVEL = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  heap_level_insert_if.slave     bus,
  input  logic [2**(CURRENT_LEVEL-1)-1:0][CNT_SIZE-1:0]  stored_cnt,
  input  logic [2**(CURRENT_LEVEL-1)-1:0][ADDR_SIZE-1:0] stored_addr,
  output logic                   write_en,
  output logic [TOTAL_LEVEL-1:0] write_index,
  output logic [CNT_SIZE-1:0]    write_cnt,
  output logic [ADDR_SIZE-1:0]   write_addr,
  output logic                   drop,
  output logic                   idx_err
);

  localparam int NUM_CNT = 2**(CURRENT_LEVEL-1);
  localparam int SLOT_W  = (CURRENT_LEVEL > 1) ? CURRENT_LEVEL-1 : 1;
  localparam logic [TOTAL_LEVEL-1:0] NUM_CNT_IDX = TOTAL_LEVEL'(NUM_CNT);
  localparam logic BOTTOM = (CURRENT_LEVEL == TOTAL_LEVEL);

  heap_state_e state_q, state_d;

  logic [TOTAL_LEVEL-1:0] tok_idx_q,  tok_idx_d;
  logic [CNT_SIZE-1:0]    tok_cnt_q,  tok_cnt_d;
  logic [ADDR_SIZE-1:0]   tok_addr_q, tok_addr_d;
  logic [TOTAL_LEVEL-1:0] fwd_idx_q,  fwd_idx_d;
  logic [CNT_SIZE-1:0]    fwd_cnt_q,  fwd_cnt_d;
  logic [ADDR_SIZE-1:0]   fwd_addr_q, fwd_addr_d;
  logic [NUM_CNT-1:0]     toggle_q,   toggle_d;

  logic [SLOT_W-1:0]      slot;
  logic [TOTAL_LEVEL-1:0] child_idx;
  logic                   in_cmp, in_push, idx_ok;
  logic                   act_write, act_fwd, fwd_now, fwd_hs;

  logic                   cs_do_write, cs_do_fwd;
  logic [CNT_SIZE-1:0]    cs_keep_cnt, cs_fwd_cnt;
  logic [ADDR_SIZE-1:0]   cs_keep_addr, cs_fwd_addr;

  assign slot      = tok_idx_q[SLOT_W-1:0];
  assign child_idx = {tok_idx_q[TOTAL_LEVEL-2:0], toggle_q[slot]};
  assign in_cmp    = (state_q == ST_CMP);
  assign in_push   = (state_q == ST_PUSH);
  assign idx_ok    = (tok_idx_q < NUM_CNT_IDX);

  heap_cmp_swap #(
    .CNT_SIZE  (CNT_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_cmp_swap (
    .tok_cnt   (tok_cnt_q),
    .tok_addr  (tok_addr_q),
    .st_cnt    (stored_cnt[slot]),
    .st_addr   (stored_addr[slot]),
    .do_write  (cs_do_write),
    .do_fwd    (cs_do_fwd),
    .keep_cnt  (cs_keep_cnt),
    .keep_addr (cs_keep_addr),
    .fwd_cnt   (cs_fwd_cnt),
    .fwd_addr  (cs_fwd_addr)
  );

  // out-of-range index suppresses both the write and the forward
  assign act_write = in_cmp && idx_ok && cs_do_write;
  assign act_fwd   = in_cmp && idx_ok && cs_do_fwd;
  assign fwd_now   = act_fwd && !BOTTOM;
  assign fwd_hs    = (fwd_now || in_push) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_CMP;
      ST_CMP:  state_d = (fwd_now && !bus.out_ready) ? ST_PUSH : ST_IDLE;
      ST_PUSH: if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE) && rst_n;
    write_en      = act_write;
    write_index   = '0;
    write_cnt     = '0;
    write_addr    = '0;
    bus.out_valid = fwd_now || in_push;
    bus.out_index = '0;
    bus.out_cnt   = '0;
    bus.out_addr  = '0;
    drop          = act_fwd && BOTTOM;
    idx_err       = in_cmp && !idx_ok;
    if (act_write) begin
      write_index = tok_idx_q;
      write_cnt   = cs_keep_cnt;
      write_addr  = cs_keep_addr;
    end
    // CMP offers the forward combinationally; PUSH replays the registered copy
    if (in_push) begin
      bus.out_index = fwd_idx_q;
      bus.out_cnt   = fwd_cnt_q;
      bus.out_addr  = fwd_addr_q;
    end else if (fwd_now) begin
      bus.out_index = child_idx;
      bus.out_cnt   = cs_fwd_cnt;
      bus.out_addr  = cs_fwd_addr;
    end
  end

  always_comb begin
    tok_idx_d  = tok_idx_q;
    tok_cnt_d  = tok_cnt_q;
    tok_addr_d = tok_addr_q;
    fwd_idx_d  = fwd_idx_q;
    fwd_cnt_d  = fwd_cnt_q;
    fwd_addr_d = fwd_addr_q;
    toggle_d   = toggle_q;
    if ((state_q == ST_IDLE) && bus.in_valid) begin
      tok_idx_d  = bus.in_index;
      tok_cnt_d  = bus.in_cnt;
      tok_addr_d = bus.in_addr;
    end
    if (fwd_now && !bus.out_ready) begin
      fwd_idx_d  = child_idx;
      fwd_cnt_d  = cs_fwd_cnt;
      fwd_addr_d = cs_fwd_addr;
    end
    if (fwd_hs) begin
      toggle_d[slot] = ~toggle_q[slot];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_idx_q  <= '0;
      tok_cnt_q  <= '0;
      tok_addr_q <= '0;
      fwd_idx_q  <= '0;
      fwd_cnt_q  <= '0;
      fwd_addr_q <= '0;
      toggle_q   <= '0;
    end else begin
      tok_idx_q  <= tok_idx_d;
      tok_cnt_q  <= tok_cnt_d;
      tok_addr_q <= tok_addr_d;
      fwd_idx_q  <= fwd_idx_d;
      fwd_cnt_q  <= fwd_cnt_d;
      fwd_addr_q <= fwd_addr_d;
      toggle_q   <= toggle_d;
    end
  end

endmodule

// File: tb/tb_heap_level_insert.sv
// Directed bench for heap_level_insert: a level-3 instance and a bottom-level (6) instance.
module tb_heap_level_insert;
  import heap_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  heap_level_insert_if #(.CNT_SIZE(20), .ADDR_SIZE(28), .TOTAL_LEVEL(6)) b3 ();
  heap_level_insert_if #(.CNT_SIZE(20), .ADDR_SIZE(28), .TOTAL_LEVEL(6)) b6 ();

  logic [3:0][19:0]  st3_cnt;
  logic [3:0][27:0]  st3_addr;
  logic [31:0][19:0] st6_cnt;
  logic [31:0][27:0] st6_addr;

  logic        we3, we6, drop3, drop6, err3, err6;
  logic [5:0]  wi3, wi6;
  logic [19:0] wc3, wc6;
  logic [27:0] wa3, wa6;

  heap_level_insert #(.CNT_SIZE(20), .ADDR_SIZE(28), .TOTAL_LEVEL(6), .CURRENT_LEVEL(3)) u3 (
    .clk (clk), .rst_n (rst_n), .bus (b3),
    .stored_cnt (st3_cnt), .stored_addr (st3_addr),
    .write_en (we3), .write_index (wi3), .write_cnt (wc3), .write_addr (wa3),
    .drop (drop3), .idx_err (err3)
  );

  heap_level_insert #(.CNT_SIZE(20), .ADDR_SIZE(28), .TOTAL_LEVEL(6), .CURRENT_LEVEL(6)) u6 (
    .clk (clk), .rst_n (rst_n), .bus (b6),
    .stored_cnt (st6_cnt), .stored_addr (st6_addr),
    .write_en (we6), .write_index (wi6), .write_cnt (wc6), .write_addr (wa6),
    .drop (drop6), .idx_err (err6)
  );

  typedef struct {
    logic [5:0]  idx;
    logic [19:0] cnt;
    logic [27:0] addr;
    logic [19:0] scnt;
    logic [27:0] saddr;
    logic        ewr;
    logic [5:0]  ewidx;
    logic [19:0] ewcnt;
    logic [27:0] ewaddr;
    logic        eov;
    logic [5:0]  eoidx;
    logic [19:0] eocnt;
    logic [27:0] eoaddr;
    logic        eerr;
  } vec_t;

  vec_t vecs [9];
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic send3(input logic [5:0] idx, input logic [19:0] cnt, input logic [27:0] addr);
    b3.in_valid = 1'b1;
    b3.in_index = idx;
    b3.in_cnt   = cnt;
    b3.in_addr  = addr;
    @(posedge clk); #1;
    b3.in_valid = 1'b0;
  endtask

  task automatic send6(input logic [5:0] idx, input logic [19:0] cnt, input logic [27:0] addr);
    b6.in_valid = 1'b1;
    b6.in_index = idx;
    b6.in_cnt   = cnt;
    b6.in_addr  = addr;
    @(posedge clk); #1;
    b6.in_valid = 1'b0;
  endtask

  task automatic check_cmp3(input string tag, input logic ewr, input logic [5:0] ewidx,
                            input logic [19:0] ewcnt, input logic [27:0] ewaddr,
                            input logic eov, input logic [5:0] eoidx, input logic [19:0] eocnt,
                            input logic [27:0] eoaddr, input logic eerr);
    chk({tag, " write_en"},    64'(we3),          64'(ewr));
    chk({tag, " write_index"}, 64'(wi3),          64'(ewidx));
    chk({tag, " write_cnt"},   64'(wc3),          64'(ewcnt));
    chk({tag, " write_addr"},  64'(wa3),          64'(ewaddr));
    chk({tag, " out_valid"},   64'(b3.out_valid), 64'(eov));
    chk({tag, " out_index"},   64'(b3.out_index), 64'(eoidx));
    chk({tag, " out_cnt"},     64'(b3.out_cnt),   64'(eocnt));
    chk({tag, " out_addr"},    64'(b3.out_addr),  64'(eoaddr));
    chk({tag, " idx_err"},     64'(err3),         64'(eerr));
    chk({tag, " drop"},        64'(drop3),        64'(0));
  endtask

  initial begin
    //         idx    cnt          addr            scnt         saddr     wr   widx   wcnt          waddr           ov   oidx   ocnt         oaddr     err
    vecs[0] = '{6'd2,  20'd5,       28'h55,         20'd0,       28'h0,    1'b1, 6'd2, 20'd5,       28'h55,         1'b0, 6'd0, 20'd0,       28'h0,    1'b0};
    vecs[1] = '{6'd1,  20'd20,      28'hB,          20'd10,      28'hA,    1'b1, 6'd1, 20'd20,      28'hB,          1'b1, 6'd2, 20'd10,      28'hA,    1'b0};
    vecs[2] = '{6'd1,  20'd20,      28'hB,          20'd10,      28'hA,    1'b1, 6'd1, 20'd20,      28'hB,          1'b1, 6'd3, 20'd10,      28'hA,    1'b0};
    vecs[3] = '{6'd0,  20'd7,       28'h70,         20'd7,       28'h33,   1'b0, 6'd0, 20'd0,       28'h0,          1'b1, 6'd0, 20'd7,       28'h70,   1'b0};
    vecs[4] = '{6'd3,  20'd3,       28'h3,          20'd9,       28'h99,   1'b0, 6'd0, 20'd0,       28'h0,          1'b1, 6'd6, 20'd3,       28'h3,    1'b0};
    vecs[5] = '{6'd1,  20'd0,       28'h12,         20'd4,       28'h44,   1'b0, 6'd0, 20'd0,       28'h0,          1'b0, 6'd0, 20'd0,       28'h0,    1'b0};
    vecs[6] = '{6'd4,  20'd8,       28'h88,         20'd0,       28'h0,    1'b0, 6'd0, 20'd0,       28'h0,          1'b0, 6'd0, 20'd0,       28'h0,    1'b1};
    vecs[7] = '{6'd0,  20'hFFFFF,   28'hFFFFFFF,    20'hFFFFE,   28'h1,    1'b1, 6'd0, 20'hFFFFF,   28'hFFFFFFF,    1'b1, 6'd1, 20'hFFFFE,   28'h1,    1'b0};
    vecs[8] = '{6'd63, 20'd1,       28'h1,          20'd0,       28'h0,    1'b0, 6'd0, 20'd0,       28'h0,          1'b0, 6'd0, 20'd0,       28'h0,    1'b1};

    rst_n = 1'b0;
    b3.in_valid = 1'b0; b3.in_index = '0; b3.in_cnt = '0; b3.in_addr = '0; b3.out_ready = 1'b1;
    b6.in_valid = 1'b0; b6.in_index = '0; b6.in_cnt = '0; b6.in_addr = '0; b6.out_ready = 1'b1;
    st3_cnt = '0; st3_addr = '0; st6_cnt = '0; st6_addr = '0;

    #12;
    chk("rst in_ready3 held", 64'(b3.in_ready),  64'(0));
    chk("rst write_en3",      64'(we3),          64'(0));
    chk("rst out_valid3",     64'(b3.out_valid), 64'(0));
    chk("rst in_ready6 held", 64'(b6.in_ready),  64'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel in_ready3",  64'(b3.in_ready),  64'(1));
    chk("rel in_ready6",  64'(b6.in_ready),  64'(1));
    chk("rel out_index3", 64'(b3.out_index), 64'(0));
    chk("rel drop6",      64'(drop6),        64'(0));
    chk("rel idx_err3",   64'(err3),         64'(0));

    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d in_ready pre", i), 64'(b3.in_ready), 64'(1));
      if (vecs[i].idx < 6'd4) begin
        st3_cnt[vecs[i].idx[1:0]]  = vecs[i].scnt;
        st3_addr[vecs[i].idx[1:0]] = vecs[i].saddr;
      end
      send3(vecs[i].idx, vecs[i].cnt, vecs[i].addr);
      chk($sformatf("v%0d in_ready cmp", i), 64'(b3.in_ready), 64'(0));
      check_cmp3($sformatf("v%0d", i), vecs[i].ewr, vecs[i].ewidx, vecs[i].ewcnt, vecs[i].ewaddr,
                 vecs[i].eov, vecs[i].eoidx, vecs[i].eocnt, vecs[i].eoaddr, vecs[i].eerr);
      @(posedge clk); #1;
      chk($sformatf("v%0d in_ready back", i), 64'(b3.in_ready),  64'(1));
      chk($sformatf("v%0d write_en off", i),  64'(we3),          64'(0));
      chk($sformatf("v%0d out_valid off", i), 64'(b3.out_valid), 64'(0));
    end

    // backpressure: swap at node 2, next level stalls for several cycles
    st3_cnt[2] = 20'd6; st3_addr[2] = 28'h6;
    b3.out_ready = 1'b0;
    send3(6'd2, 20'd12, 28'hC);
    check_cmp3("bp cmp", 1'b1, 6'd2, 20'd12, 28'hC, 1'b1, 6'd4, 20'd6, 28'h6, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      st3_cnt[2] = 20'd12; st3_addr[2] = 28'hC;
      chk($sformatf("bp%0d out_valid", k), 64'(b3.out_valid), 64'(1));
      chk($sformatf("bp%0d out_index", k), 64'(b3.out_index), 64'(4));
      chk($sformatf("bp%0d out_cnt", k),   64'(b3.out_cnt),   64'(6));
      chk($sformatf("bp%0d out_addr", k),  64'(b3.out_addr),  64'(6));
      chk($sformatf("bp%0d in_ready", k),  64'(b3.in_ready),  64'(0));
      chk($sformatf("bp%0d write_en", k),  64'(we3),          64'(0));
    end
    b3.out_ready = 1'b1;
    #1;
    chk("bp release out_valid", 64'(b3.out_valid), 64'(1));
    @(posedge clk); #1;
    chk("bp after in_ready",  64'(b3.in_ready),  64'(1));
    chk("bp after out_valid", 64'(b3.out_valid), 64'(0));
    send3(6'd2, 20'd1, 28'h11);
    check_cmp3("bp toggle", 1'b0, 6'd0, 20'd0, 28'h0, 1'b1, 6'd5, 20'd1, 28'h11, 1'b0);
    @(posedge clk); #1;

    // bottom level: everything forwarded is dropped
    st6_cnt[17] = 20'd4; st6_addr[17] = 28'h44;
    send6(6'd17, 20'd9, 28'h99);
    chk("bot swap write_en",    64'(we6),          64'(1));
    chk("bot swap write_index", 64'(wi6),          64'(17));
    chk("bot swap write_cnt",   64'(wc6),          64'(9));
    chk("bot swap write_addr",  64'(wa6),          64'(28'h99));
    chk("bot swap drop",        64'(drop6),        64'(1));
    chk("bot swap out_valid",   64'(b6.out_valid), 64'(0));
    @(posedge clk); #1;
    chk("bot swap in_ready",    64'(b6.in_ready),  64'(1));
    chk("bot swap drop off",    64'(drop6),        64'(0));
    st6_cnt[31] = 20'd4; st6_addr[31] = 28'h44;
    send6(6'd31, 20'd2, 28'h22);
    chk("bot pass write_en",  64'(we6),          64'(0));
    chk("bot pass drop",      64'(drop6),        64'(1));
    chk("bot pass out_valid", 64'(b6.out_valid), 64'(0));
    @(posedge clk); #1;
    st6_cnt[5] = 20'd4;
    send6(6'd5, 20'd0, 28'h5);
    chk("bot null drop",     64'(drop6), 64'(0));
    chk("bot null write_en", 64'(we6),   64'(0));
    @(posedge clk); #1;
    send6(6'd32, 20'd3, 28'h3);
    chk("bot idx_err",      64'(err6), 64'(1));
    chk("bot err write_en", 64'(we6),  64'(0));
    chk("bot err drop",     64'(drop6), 64'(0));
    @(posedge clk); #1;

    // reset while a write is pending in CMP; node 3 toggle is 1 before this
    st3_cnt[0] = 20'd0;
    send3(6'd0, 20'd5, 28'h5);
    chk("rmid pre write_en", 64'(we3), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rmid write_en",  64'(we3),          64'(0));
    chk("rmid out_valid", 64'(b3.out_valid), 64'(0));
    chk("rmid in_ready",  64'(b3.in_ready),  64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rmid idle in_ready", 64'(b3.in_ready), 64'(1));
    chk("rmid idle write_en", 64'(we3),         64'(0));
    st3_cnt[3] = 20'd9; st3_addr[3] = 28'h99;
    send3(6'd3, 20'd1, 28'h1);
    check_cmp3("rmid toggle", 1'b0, 6'd0, 20'd0, 28'h0, 1'b1, 6'd6, 20'd1, 28'h1, 1'b0);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
